// File: rtl/rgb_pwm_ctrl.sv
// rgb_pwm_ctrl: button-driven RGB PWM controller.
// Two raw active-low buttons are synchronised and debounced. A cycles the
// selected colour channel; B steps that channel's duty. Three registered PWM
// outputs run from a free-running counter, with duty loaded only at period end.
module rgb_pwm_ctrl #(
  parameter int unsigned PWM_BITS        = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 48000,
  parameter int unsigned DUTY_STEP       = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_a_n,
  input  logic       btn_b_n,
  output logic       pwm_r,
  output logic       pwm_g,
  output logic       pwm_b,
  output logic [1:0] sel,
  output logic       press_a,
  output logic       press_b
);

  localparam int unsigned DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DBW-1:0]      DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] STEP    = PWM_BITS'(DUTY_STEP);
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    SEL_R = 2'd0,
    SEL_G = 2'd1,
    SEL_B = 2'd2
  } sel_e;

  // Index 0 = button A, index 1 = button B.
  logic [1:0]          sync1_q, sync2_q;
  logic [1:0]          lvl_q, lvl_d;
  logic [1:0]          lvl_dly_q;
  logic [1:0]          press_q, press_d;
  logic [DBW-1:0]      db_cnt_q [2];
  logic [DBW-1:0]      db_cnt_d [2];

  sel_e                state_q, state_d;

  logic [PWM_BITS-1:0] duty_q   [3];
  logic [PWM_BITS-1:0] duty_d   [3];
  logic [PWM_BITS-1:0] shadow_q [3];
  logic [PWM_BITS-1:0] shadow_d [3];
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [2:0]          pwm_q, pwm_d;

  // Debounce: count consecutive samples that differ from the debounced level.
  always_comb begin
    lvl_d    = lvl_q;
    db_cnt_d = db_cnt_q;
    for (int unsigned i = 0; i < 2; i++) begin
      if (sync2_q[i] == lvl_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        lvl_d[i]    = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
      end
    end
    // Pulse the cycle after the debounced level falls.
    press_d = lvl_dly_q & ~lvl_q;
  end

  // Channel select FSM: next state and sel output.
  always_comb begin
    state_d = state_q;
    sel     = state_q;
    if (press_q[0]) begin
      case (state_q)
        SEL_R:   state_d = SEL_G;
        SEL_G:   state_d = SEL_B;
        default: state_d = SEL_R;
      endcase
    end
  end

  // Duty stepping, period-aligned shadow load and PWM compare.
  always_comb begin
    duty_d   = duty_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q + PWM_BITS'(1);
    pwm_d    = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      // The increment targets the channel selected before any same-cycle advance.
      if (press_q[1] && (state_q == 2'(i))) begin
        duty_d[i] = duty_q[i] + STEP;
      end
      if (cnt_q == CNT_MAX) begin
        shadow_d[i] = duty_q[i];
      end
      // Compare against the next count so the registered output lines up with cnt_q.
      pwm_d[i] = (cnt_d < shadow_d[i]);
    end
  end

  // All state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      lvl_q     <= '1;
      lvl_dly_q <= '1;
      press_q   <= '0;
      db_cnt_q  <= '{default: '0};
      state_q   <= SEL_R;
      duty_q    <= '{default: '0};
      shadow_q  <= '{default: '0};
      cnt_q     <= '0;
      pwm_q     <= '0;
    end else begin
      sync1_q   <= {btn_b_n, btn_a_n};
      sync2_q   <= sync1_q;
      lvl_q     <= lvl_d;
      lvl_dly_q <= lvl_q;
      press_q   <= press_d;
      db_cnt_q  <= db_cnt_d;
      state_q   <= state_d;
      duty_q    <= duty_d;
      shadow_q  <= shadow_d;
      cnt_q     <= cnt_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm_r   = pwm_q[0];
  assign pwm_g   = pwm_q[1];
  assign pwm_b   = pwm_q[2];
  assign press_a = press_q[0];
  assign press_b = press_q[1];

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Bench for rgb_pwm_ctrl: directed scenarios plus randomized button traffic,
// every cycle compared against a behavioural model of the controller.
module tb_rgb_pwm_ctrl;

  localparam int PB  = 4;
  localparam int DB  = 4;
  localparam int ST  = 4;
  localparam int PER = 1 << PB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, btn_a_n, btn_b_n;
  logic pwm_r, pwm_g, pwm_b, press_a, press_b;
  logic [1:0] sel;
  logic d_pwm_r, d_pwm_g, d_pwm_b, d_press_a, d_press_b;
  logic [1:0] d_sel;

  rgb_pwm_ctrl #(.PWM_BITS(PB), .DEBOUNCE_CYCLES(DB), .DUTY_STEP(ST)) dut (
    .clk(clk), .rst_n(rst_n), .btn_a_n(btn_a_n), .btn_b_n(btn_b_n),
    .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b), .sel(sel),
    .press_a(press_a), .press_b(press_b)
  );

  rgb_pwm_ctrl u_def (
    .clk(clk), .rst_n(rst_n), .btn_a_n(1'b1), .btn_b_n(1'b1),
    .pwm_r(d_pwm_r), .pwm_g(d_pwm_g), .pwm_b(d_pwm_b), .sel(d_sel),
    .press_a(d_press_a), .press_b(d_press_b)
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model. m_c is the period position (edges since reset mod PER),
  // m_run the length of the current run of synchronised samples disagreeing
  // with the debounced level.
  bit m_s1[2], m_s2[2], m_lvl[2], m_fell[2], m_press[2];
  int m_run[2];
  int m_sel;
  int m_duty[3], m_shadow[3];
  int m_c;
  bit m_pwm[3];

  task automatic model_edge(input bit rst, input bit ra, input bit rb);
    bit old_pa, old_pb;
    bit raw[2];
    raw[0] = ra;
    raw[1] = rb;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_s1[i] = 1; m_s2[i] = 1; m_lvl[i] = 1;
        m_run[i] = 0; m_fell[i] = 0; m_press[i] = 0;
      end
      m_sel = 0;
      for (int i = 0; i < 3; i++) begin
        m_duty[i] = 0; m_shadow[i] = 0; m_pwm[i] = 0;
      end
      m_c = 0;
    end else begin
      old_pa = m_press[0];
      old_pb = m_press[1];
      if (m_c == PER - 1)
        for (int i = 0; i < 3; i++) m_shadow[i] = m_duty[i];
      m_c = (m_c + 1) % PER;
      for (int i = 0; i < 3; i++) m_pwm[i] = (m_c < m_shadow[i]);
      if (old_pb) m_duty[m_sel] = (m_duty[m_sel] + ST) % PER;
      if (old_pa) m_sel = (m_sel + 1) % 3;
      for (int i = 0; i < 2; i++) begin
        m_press[i] = m_fell[i];
        m_fell[i]  = 0;
        if (m_s2[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_lvl[i]  = m_s2[i];
            m_run[i]  = 0;
            m_fell[i] = (m_lvl[i] == 0);
          end
        end else begin
          m_run[i] = 0;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = raw[i];
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic step();
    logic [6:0] exp_v;
    @(posedge clk);
    #1;
    model_edge(rst_n, btn_a_n, btn_b_n);
    exp_v = {m_pwm[0], m_pwm[1], m_pwm[2], 2'(m_sel), m_press[0], m_press[1]};
    chk("cycle", {25'd0, pwm_r, pwm_g, pwm_b, sel, press_a, press_b}, {25'd0, exp_v});
  endtask

  task automatic press_btn(input bit a, input bit b);
    if (a) btn_a_n = 1'b0;
    if (b) btn_b_n = 1'b0;
    repeat (9) step();
    btn_a_n = 1'b1;
    btn_b_n = 1'b1;
    repeat (9) step();
  endtask

  task automatic wait_press(input bit is_b, input int max, output int n);
    n = -1;
    for (int k = 1; k <= max; k++) begin
      step();
      if ((is_b ? press_b : press_a) === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  // Record one full period starting at cnt = 0.
  task automatic measure(output logic [15:0] pr, output logic [15:0] pg, output logic [15:0] pb);
    int k = 0;
    pr = '0; pg = '0; pb = '0;
    while (m_c != PER - 1 && k < 40) begin
      step();
      k++;
    end
    for (int i = 0; i < PER; i++) begin
      step();
      pr[i] = pwm_r;
      pg[i] = pwm_g;
      pb[i] = pwm_b;
    end
  endtask

  initial begin
    logic [15:0] pr, pg, pb;
    int n, cnt_p, k;

    rst_n = 1'b0; btn_a_n = 1'b1; btn_b_n = 1'b1;
    repeat (3) step();
    chk("reset_def_outputs", {d_pwm_r, d_pwm_g, d_pwm_b, d_sel, d_press_a, d_press_b}, 0);
    chk("reset_outputs", {pwm_r, pwm_g, pwm_b, sel, press_a, press_b}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      step();
      chk("idle_def", {d_pwm_r, d_pwm_g, d_pwm_b, d_sel, d_press_a, d_press_b}, 0);
    end

    // Debounce: short burst rejected, then a held press.
    btn_a_n = 1'b0;
    repeat (3) begin step(); chk("burst_no_press", press_a, 0); end
    btn_a_n = 1'b1;
    step(); chk("burst_no_press", press_a, 0);
    btn_a_n = 1'b0;
    wait_press(1'b0, 20, n);
    chk("press_a_latency", n, 7);
    step();
    chk("sel_after_a", sel, 1);
    btn_a_n = 1'b1;
    cnt_p = 0;
    repeat (12) begin step(); if (press_a) cnt_p++; end
    chk("release_no_pulse", cnt_p, 0);

    // Back to R, then duty_r = 8.
    press_btn(1, 0);
    press_btn(1, 0);
    chk("sel_back_r", sel, 0);
    press_btn(0, 1);
    press_btn(0, 1);
    measure(pr, pg, pb);
    chk("duty_r8_pattern", pr, 16'h00FF);
    chk("duty_r8_g_off", pg, 16'h0000);
    chk("duty_r8_b_off", pb, 16'h0000);

    // Wrap on G: 4, 8, 12, then 0.
    press_btn(1, 0);
    chk("sel_g", sel, 1);
    press_btn(0, 1);
    press_btn(0, 1);
    press_btn(0, 1);
    measure(pr, pg, pb);
    chk("duty_g12_pattern", pg, 16'h0FFF);
    chk("duty_r_kept", pr, 16'h00FF);
    press_btn(0, 1);
    measure(pr, pg, pb);
    chk("duty_g_wrap0", pg, 16'h0000);

    // Mid-period update: press_b lands at cnt = 5.
    k = 0;
    while (m_c != 14 && k < 40) begin step(); k++; end
    btn_b_n = 1'b0;
    repeat (7) step();
    chk("press_b_mid", press_b, 1);
    btn_b_n = 1'b1;
    cnt_p = 0;
    k = 0;
    while (m_c != PER - 1 && k < 40) begin step(); if (pwm_g) cnt_p++; k++; end
    chk("mid_period_old_duty", cnt_p, 0);
    pg = '0;
    for (int i = 0; i < PER; i++) begin step(); pg[i] = pwm_g; end
    chk("mid_period_new_duty", pg, 16'h000F);

    // Simultaneous presses at sel = B.
    press_btn(1, 0);
    chk("sel_b", sel, 2);
    press_btn(1, 1);
    chk("simul_sel_wrap", sel, 0);
    measure(pr, pg, pb);
    chk("simul_duty_b", pb, 16'h000F);
    chk("simul_duty_r", pr, 16'h00FF);
    chk("simul_duty_g", pg, 16'h000F);

    // Reset while B is mid-debounce.
    btn_b_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    chk("reset_mid_outputs", {pwm_r, pwm_g, pwm_b, sel, press_a, press_b}, 0);
    btn_b_n = 1'b1;
    step();
    rst_n = 1'b1;
    cnt_p = 0;
    repeat (20) begin step(); if (press_b) cnt_p++; end
    chk("reset_no_stale_press", cnt_p, 0);
    btn_b_n = 1'b0;
    wait_press(1'b1, 20, n);
    chk("fresh_press_b_latency", n, 7);
    btn_b_n = 1'b1;
    repeat (9) step();

    // Randomized button traffic with occasional resets.
    for (int r = 0; r < 300; r++) begin
      btn_a_n = 1'($urandom_range(0, 1));
      btn_b_n = 1'($urandom_range(0, 1));
      rst_n   = ($urandom_range(0, 59) != 0);
      repeat ($urandom_range(1, 10)) step();
    end
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
